hold_pipe_multi: RTL

//  - Parametrised successor to the single-register hold/load test block: DEPTH-stage, LANES-wide elastic pipeline.
//  - Each stage either holds its value (stall) or loads from upstream.
//  - Stall/flush/valid control is public (sanitized); lane data is secret (taint source in, taint sink out).
//  - Control flow and timing never depend on data. Used as a constant-time verification target and a reusable buffer.

---
 rtl/hold_pipe_multi.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hold_pipe_multi.sv
`default_nettype none
// ============================================================================
// Module   : hold_pipe_multi
// Brief    : DEPTH-stage, LANES-wide elastic pipeline. Each stage holds on
//            stall or loads from upstream. Control (valid/ready/count) is
//            derived only from public control inputs; lane data only moves
//            through the data registers and never reaches a public output.
//            COLLAPSE=0 stalls all stages together; COLLAPSE=1 lets upstream
//            stages fill empty downstream slots (bubble collapsing).
// Revision : 1.0 - initial release
// ============================================================================
module hold_pipe_multi #(
  parameter int WIDTH    = 8,
  parameter int LANES    = 4,
  parameter int DEPTH    = 3,
  parameter int COLLAPSE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           in_keep,
  input  logic [WIDTH*LANES-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*LANES-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int DW    = WIDTH * LANES;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DW-1:0]    d_q [DEPTH];
  logic [DW-1:0]    d_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [DEPTH:0]   rdy;
  logic [DW-1:0]    in_masked;

  // Zero the lanes whose keep bit is clear before they enter stage 0.
  always_comb begin
    in_masked = '0;
    for (int l = 0; l < LANES; l++) begin
      if (in_keep[l]) begin
        in_masked[l*WIDTH +: WIDTH] = in_data[l*WIDTH +: WIDTH];
      end
    end
  end

  // Ready chain: one shared stall, or per-stage "room at or below me".
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (COLLAPSE != 0) begin
        rdy[i] = ~v_q[i] | rdy[i+1];
      end else begin
        rdy[i] = out_ready | ~v_q[DEPTH-1];
      end
    end
  end

  // Stage next-state: flush clears everything, otherwise ready stages load
  // from upstream (invalid beats move too, so timing never depends on data).
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end
    if (flush) begin
      v_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_d[i] = '0;
      end
    end else begin
      if (rdy[0]) begin
        v_d[0] = in_valid;
        d_d[0] = in_masked;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_d[i] = v_q[i-1];
          d_d[i] = d_q[i-1];
        end
      end
    end
  end

  // Occupancy is the population count of the next valid vector.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(v_d[i]);
    end
  end

  // State registers; reset dominates flush and load.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

endmodule
`default_nettype wire
